// File: rtl/score_pkg.sv
// Shared types and constants for the score_keeper game-state producer.
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam int POINTS_W = 10;
    localparam int LEVEL_W  = 4;
    localparam int SUM_W    = 11;

    localparam logic [SUM_W-1:0] MAX_POINTS = 11'd999;

endpackage

// File: rtl/score_keeper_hold_timer.sv
// Load/decrement down-counter that times the level-up hold; o_done flags a zero count.
module hold_timer
    import score_pkg::*;
#(
    parameter int CNT_W = 26
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_value,
    input  logic             i_dec,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/score_keeper.sv
// Accumulates scoring events into a saturating 0..999 total and advances the level.
// Build option: define SCORE_KEEPER_LEVELUP_HOLD_EN to pause intake for LEVELUP_HOLD cycles after a level-up.
module score_keeper
    import score_pkg::*;
#(
    parameter int POINTS_PER_LEVEL = 100,
    parameter int MAX_LEVEL        = 9,
    parameter int LEVELUP_HOLD     = 50_000_000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                event_valid,
    input  logic [3:0]          event_value,
    output logic                event_ready,
    output logic [POINTS_W-1:0] points,
    output logic [LEVEL_W-1:0]  level,
    output logic                level_up,
    output logic                game_over
);

    localparam logic [SUM_W-1:0] PPL = SUM_W'(POINTS_PER_LEVEL);

    if ((POINTS_PER_LEVEL < 16) || (POINTS_PER_LEVEL > 999) ||
        (MAX_LEVEL < 2) || (MAX_LEVEL > 15) || (LEVELUP_HOLD < 1)) begin : g_bad_params
        $error("score_keeper: parameter out of legal range");
    end

    function automatic logic [POINTS_W-1:0] sat_points(input logic [SUM_W-1:0] sum);
        return (sum > MAX_POINTS) ? POINTS_W'(MAX_POINTS) : sum[POINTS_W-1:0];
    endfunction

    state_t              r_state;
    state_t              w_state_next;
    logic [POINTS_W-1:0] r_points;
    logic [LEVEL_W-1:0]  r_level;
    logic [SUM_W-1:0]    r_threshold;

    logic [SUM_W-1:0]    w_sum;
    logic [LEVEL_W-1:0]  w_next_level;
    logic                w_accept;
    logic                w_levelup;
    logic                w_final;

    assign w_accept     = event_valid && event_ready;
    assign w_sum        = SUM_W'(r_points) + SUM_W'(event_value);
    // Compare against the unsaturated sum so a saturated total can never retrigger.
    assign w_levelup    = w_accept && (w_sum >= r_threshold);
    assign w_next_level = r_level + 1'b1;
    assign w_final      = (w_next_level == LEVEL_W'(MAX_LEVEL));

`ifdef SCORE_KEEPER_LEVELUP_HOLD_EN
    localparam int HOLD_W = (LEVELUP_HOLD > 1) ? $clog2(LEVELUP_HOLD) : 1;

    logic w_hold_load;
    logic w_hold_done;

    hold_timer #(
        .CNT_W(HOLD_W)
    ) u_hold_timer (
        .clock       (clock),
        .reset       (reset),
        .i_load      (w_hold_load),
        .i_load_value(HOLD_W'(LEVELUP_HOLD - 1)),
        .i_dec       (r_state == ST_HOLD),
        .o_done      (w_hold_done)
    );
`endif

    always_comb begin
        w_state_next = r_state;
`ifdef SCORE_KEEPER_LEVELUP_HOLD_EN
        w_hold_load  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_levelup) begin
                    if (w_final) begin
                        w_state_next = ST_OVER;
                    end else begin
`ifdef SCORE_KEEPER_LEVELUP_HOLD_EN
                        w_state_next = ST_HOLD;
                        w_hold_load  = 1'b1;
`else
                        w_state_next = ST_IDLE;
`endif
                    end
                end
            end
            ST_HOLD: begin
`ifdef SCORE_KEEPER_LEVELUP_HOLD_EN
                if (w_hold_done) begin
                    w_state_next = ST_IDLE;
                end
`else
                w_state_next = ST_IDLE;
`endif
            end
            ST_OVER: begin
                w_state_next = ST_OVER;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_points    <= '0;
            r_level     <= LEVEL_W'(1);
            r_threshold <= PPL;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_points <= sat_points(w_sum);
            end
            if (w_levelup) begin
                r_level     <= w_next_level;
                r_threshold <= r_threshold + PPL;
            end
        end
    end

    assign event_ready = (r_state == ST_IDLE);
    assign game_over   = (r_state == ST_OVER);
    assign points      = r_points;
    assign level       = r_level;

`ifdef SCORE_KEEPER_LEVELUP_HOLD_EN
    assign level_up = (r_state == ST_HOLD);
`else
    // Without a hold state, level_up is a one-cycle flag for non-final level-ups.
    logic r_level_up;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_level_up <= 1'b0;
        end else begin
            r_level_up <= w_levelup && !w_final;
        end
    end

    assign level_up = r_level_up;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: vector table, corner sequences and random stimulus against a points/level model.
module tb_score_keeper;

    localparam int PPL  = 100;
    localparam int HOLD = 4;
`ifdef SCORE_KEEPER_LEVELUP_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       event_valid = 1'b0;
    logic [3:0] event_value = 4'd0;

    logic       rdy9, lu9, go9, rdy15, lu15, go15;
    logic [9:0] pts9, pts15;
    logic [3:0] lvl9, lvl15;

    score_keeper #(.POINTS_PER_LEVEL(PPL), .MAX_LEVEL(9), .LEVELUP_HOLD(HOLD)) dut (
        .clock(clock), .reset(reset), .event_valid(event_valid), .event_value(event_value),
        .event_ready(rdy9), .points(pts9), .level(lvl9), .level_up(lu9), .game_over(go9)
    );

    score_keeper #(.POINTS_PER_LEVEL(PPL), .MAX_LEVEL(15), .LEVELUP_HOLD(HOLD)) dut15 (
        .clock(clock), .reset(reset), .event_valid(event_valid), .event_value(event_value),
        .event_ready(rdy15), .points(pts15), .level(lvl15), .level_up(lu15), .game_over(go15)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference state per instance: 0 -> MAX_LEVEL 9, 1 -> MAX_LEVEL 15.
    int m_points[2];
    int m_level[2];
    int m_thr[2];
    int m_hold[2];
    bit m_over[2];
    bit m_pulse[2];
    int m_max[2] = '{9, 15};

    typedef struct {
        bit rst;
        bit vld;
        int val;
        int p;
        int l;
        bit r;
        bit lu;
        bit go;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit m_ready(input int k);
        return !m_over[k] && (m_hold[k] == 0);
    endfunction

    function automatic bit m_lu(input int k);
        return HOLD_EN ? (m_hold[k] > 0) : m_pulse[k];
    endfunction

    task automatic model_step(input int k, input bit v, input int val, input bit r);
        int sum;
        bit rdy;
        if (r) begin
            m_points[k] = 0;
            m_level[k]  = 1;
            m_thr[k]    = PPL;
            m_hold[k]   = 0;
            m_over[k]   = 1'b0;
            m_pulse[k]  = 1'b0;
            return;
        end
        rdy = m_ready(k);
        if (m_hold[k] > 0) m_hold[k]--;
        m_pulse[k] = 1'b0;
        if (v && rdy) begin
            sum = m_points[k] + val;
            m_points[k] = (sum > 999) ? 999 : sum;
            if (sum >= m_thr[k]) begin
                m_level[k]++;
                m_thr[k] += PPL;
                if (m_level[k] == m_max[k]) m_over[k] = 1'b1;
                else if (HOLD_EN) m_hold[k] = HOLD;
                else m_pulse[k] = 1'b1;
            end
        end
    endtask

    task automatic check_model();
        chk("model9 points", int'(pts9), m_points[0]);
        chk("model9 level", int'(lvl9), m_level[0]);
        chk("model9 ready", int'(rdy9), int'(m_ready(0)));
        chk("model9 level_up", int'(lu9), int'(m_lu(0)));
        chk("model9 game_over", int'(go9), int'(m_over[0]));
        chk("model15 points", int'(pts15), m_points[1]);
        chk("model15 level", int'(lvl15), m_level[1]);
        chk("model15 ready", int'(rdy15), int'(m_ready(1)));
        chk("model15 level_up", int'(lu15), int'(m_lu(1)));
        chk("model15 game_over", int'(go15), int'(m_over[1]));
    endtask

    // One clock: drive inputs, advance model on the edge, sample 1 time unit later.
    task automatic cycle(input bit v, input int val, input bit r);
        event_valid = v;
        event_value = 4'(val);
        reset       = r;
        @(posedge clock);
        for (int k = 0; k < 2; k++) model_step(k, v, val, r);
        #1;
        check_model();
    endtask

    task automatic pump(input int k, input int target);
        int guard;
        int rem;
        guard = 0;
        while ((m_points[k] < target) && (guard < 3000)) begin
            rem = target - m_points[k];
            cycle(1'b1, (rem > 15) ? 15 : rem, 1'b0);
            guard++;
        end
        chk("pump within budget", int'(guard < 3000), 1);
    endtask

    function automatic vec_t mk(input bit rst, input bit vld, input int val, input int p,
                                input int l, input bit r, input bit lu, input bit go);
        vec_t x;
        x.rst = rst; x.vld = vld; x.val = val; x.p = p;
        x.l = l; x.r = r; x.lu = lu; x.go = go;
        return x;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) model_step(k, 1'b0, 0, 1'b1);

        // Reset, small events, run-up to 95, then the first level-up.
        tbl.push_back(mk(1, 0, 0,   0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 5,   5, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 7,  12, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0,  12, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 15, 27, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 15, 42, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 15, 57, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 15, 72, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8,  80, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 15, 95, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 9, 104, 2, !HOLD_EN, 1, 0));
        if (HOLD_EN) begin
            tbl.push_back(mk(0, 1, 3, 104, 2, 0, 1, 0));
            tbl.push_back(mk(0, 1, 3, 104, 2, 0, 1, 0));
            tbl.push_back(mk(0, 1, 3, 104, 2, 0, 1, 0));
            tbl.push_back(mk(0, 1, 3, 104, 2, 1, 0, 0));
            tbl.push_back(mk(0, 1, 3, 107, 2, 1, 0, 0));
        end else begin
            tbl.push_back(mk(0, 1, 3, 107, 2, 1, 0, 0));
            tbl.push_back(mk(0, 1, 0, 107, 2, 1, 0, 0));
        end

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].vld, tbl[i].val, tbl[i].rst);
            chk($sformatf("vec%0d points", i), int'(pts9), tbl[i].p);
            chk($sformatf("vec%0d level", i), int'(lvl9), tbl[i].l);
            chk($sformatf("vec%0d ready", i), int'(rdy9), int'(tbl[i].r));
            chk($sformatf("vec%0d level_up", i), int'(lu9), int'(tbl[i].lu));
            chk($sformatf("vec%0d game_over", i), int'(go9), int'(tbl[i].go));
        end

        // Game over: 795 at level 8, +10 reaches level 9 = MAX_LEVEL.
        pump(0, 795);
        chk("pre-over points", int'(pts9), 795);
        chk("pre-over level", int'(lvl9), 8);
        cycle(1'b1, 10, 1'b0);
        chk("over points", int'(pts9), 805);
        chk("over level", int'(lvl9), 9);
        chk("over game_over", int'(go9), 1);
        chk("over ready", int'(rdy9), 0);
        chk("over level_up", int'(lu9), 0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 15, 1'b0);
        chk("over frozen points", int'(pts9), 805);
        chk("over frozen level", int'(lvl9), 9);
        chk("over frozen game_over", int'(go9), 1);

        // Saturation on the MAX_LEVEL=15 instance.
        pump(1, 995);
        chk("sat pre points", int'(pts15), 995);
        chk("sat pre level", int'(lvl15), 10);
        cycle(1'b1, 15, 1'b0);
        chk("sat points", int'(pts15), 999);
        chk("sat level", int'(lvl15), 11);
        for (int i = 0; i < 10; i++) cycle(1'b1, 15, 1'b0);
        chk("sat hold points", int'(pts15), 999);
        chk("sat hold level", int'(lvl15), 11);
        chk("sat ready", int'(rdy15), 1);
        chk("over still frozen", int'(pts9), 805);

        // Reset on the second HOLD cycle.
        cycle(1'b0, 0, 1'b1);
        pump(0, 95);
        cycle(1'b1, 9, 1'b0);
        cycle(1'b1, 3, 1'b0);
        chk("mid-hold points", int'(pts9), HOLD_EN ? 104 : 107);
        chk("mid-hold level_up", int'(lu9), int'(HOLD_EN));
        cycle(1'b0, 0, 1'b1);
        chk("rst points", int'(pts9), 0);
        chk("rst level", int'(lvl9), 1);
        chk("rst ready", int'(rdy9), 1);
        chk("rst level_up", int'(lu9), 0);
        chk("rst game_over", int'(go9), 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
                  $urandom_range(0, 149) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
